// File: rtl/event_window_pkg.sv
// Shared definitions for the event window counter: FSM encoding, default
// parameter values and timer sizing.
package event_window_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int WINDOW_DEFAULT = 16;
   localparam int CW_DEFAULT     = 8;

   // Timer counts 0 .. window-1; at least one bit even for tiny windows.
   function automatic int timer_width(input int window);
      return (window <= 2) ? 1 : $clog2(window);
   endfunction

endpackage

// File: rtl/event_window_counter_rise_detect.sv
// Delay register for the detector output plus a single-cycle rising-edge pulse.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q_d,
   output logic rise
);

   // NOTE: registered state always uses non-blocking assignments so every
   // flop samples the pre-edge value of its inputs.
   always_ff @(posedge clk) begin
      if (rst) q_d <= 1'b0;
      else     q_d <= d;
   end

   assign rise = d & ~q_d;

endmodule

// File: rtl/event_window_counter.sv
// Counts detector events over fixed windows of WINDOW cycles and presents
// each window's count/overflow through a valid/ack result register.
module event_window_counter
   import event_window_pkg::*;
#(
   parameter int WINDOW    = WINDOW_DEFAULT,
   parameter int CW        = CW_DEFAULT,
   parameter int EDGE_MODE = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          F,
   input  logic          en,
   input  logic          ack,
   output logic [CW-1:0] count,
   output logic          ovf,
   output logic          valid,
   output logic          busy
);

   localparam int TW = timer_width(WINDOW);

   state_e          state, state_n;
   logic [CW-1:0]   acc, acc_n;
   logic            ovf_acc, ovf_acc_n;
   logic [TW-1:0]   timer, timer_n;
   logic [CW-1:0]   count_n;
   logic            ovf_n, valid_n;
   logic            rise, evt;
   logic            unused_f_d;

   rise_detect u_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (F),
      .q_d  (unused_f_d),
      .rise (rise)
   );

   assign evt = (EDGE_MODE != 0) ? rise : F;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_n   = state;
      acc_n     = acc;
      ovf_acc_n = ovf_acc;
      timer_n   = timer;
      count_n   = count;
      ovf_n     = ovf;
      valid_n   = valid;

      case (state)
         IDLE: begin
            if (en) begin
               state_n   = COUNT;
               timer_n   = '0;
               acc_n     = '0;
               ovf_acc_n = 1'b0;
            end
         end

         COUNT: begin
            if (evt) begin
               if (acc == {CW{1'b1}}) ovf_acc_n = 1'b1;
               else                   acc_n     = acc + CW'(1);
            end
            timer_n = timer + TW'(1);
            // Last sampled cycle: its event is already folded into acc_n.
            if (timer == TW'(WINDOW - 1)) begin
               count_n = acc_n;
               ovf_n   = ovf_acc_n;
               valid_n = 1'b1;
               state_n = HOLD;
            end
         end

         HOLD: begin
            if (ack) begin
               valid_n = 1'b0;
               if (en) begin
                  state_n   = COUNT;
                  timer_n   = '0;
                  acc_n     = '0;
                  ovf_acc_n = 1'b0;
               end else begin
                  state_n = IDLE;
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         ovf_acc <= 1'b0;
         timer   <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         valid   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         ovf_acc <= ovf_acc_n;
         timer   <= timer_n;
         count   <= count_n;
         ovf     <= ovf_n;
         valid   <= valid_n;
         busy    <= (state_n == COUNT);
      end
   end

endmodule
